// File: rtl/gpio_input_filter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_input_filter_bank
//  Description : Multi-channel GPIO input conditioning bank. Each channel has
//                a synchronizer chain, an optional debounce filter and
//                rise/fall edge detection. Edges set sticky per-channel
//                interrupt-pending bits.
//
//  Ports       : clk_i             - single clock for all logic
//                rst_i             - synchronous active-high reset
//                en_i              - per-channel enable (low freezes path)
//                serial_i          - asynchronous pad inputs
//                debounce_en_i     - per-channel debounce enable
//                debounce_cycles_i - shared debounce threshold T
//                rise_irq_en_i     - rising edge sets pending
//                fall_irq_en_i     - falling edge sets pending
//                irq_clr_i         - one-cycle clear of the pending bit
//                serial_o          - filtered, synchronized level
//                r_edge_o          - one-cycle rising-edge pulse
//                f_edge_o          - one-cycle falling-edge pulse
//                irq_pending_o     - sticky pending bits
//                irq_o             - OR of all pending bits
//
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_filter_bank #(
    parameter int NR_CHANNELS        = 32,
    parameter int NR_SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CNT_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NR_CHANNELS-1:0]        en_i,
    input  logic [NR_CHANNELS-1:0]        serial_i,
    input  logic [NR_CHANNELS-1:0]        debounce_en_i,
    input  logic [DEBOUNCE_CNT_WIDTH-1:0] debounce_cycles_i,
    input  logic [NR_CHANNELS-1:0]        rise_irq_en_i,
    input  logic [NR_CHANNELS-1:0]        fall_irq_en_i,
    input  logic [NR_CHANNELS-1:0]        irq_clr_i,
    output logic [NR_CHANNELS-1:0]        serial_o,
    output logic [NR_CHANNELS-1:0]        r_edge_o,
    output logic [NR_CHANNELS-1:0]        f_edge_o,
    output logic [NR_CHANNELS-1:0]        irq_pending_o,
    output logic                          irq_o
);

    localparam logic [DEBOUNCE_CNT_WIDTH-1:0] C_CNT_ONE = DEBOUNCE_CNT_WIDTH'(1);

    logic [NR_CHANNELS-1:0] w_filt;
    logic [NR_CHANNELS-1:0] w_prev;
    logic [NR_CHANNELS-1:0] w_r_edge;
    logic [NR_CHANNELS-1:0] w_f_edge;
    logic [NR_CHANNELS-1:0] w_pend_set;
    logic [NR_CHANNELS-1:0] r_pending;

    for (genvar i = 0; i < NR_CHANNELS; i++) begin : g_ch
        logic [NR_SYNC_STAGES-1:0]     r_sync;
        logic                          w_sync;
        logic [DEBOUNCE_CNT_WIDTH-1:0] r_cnt;
        logic                          r_filt;
        logic                          r_prev;

        assign w_sync = r_sync[NR_SYNC_STAGES-1];

        // Shift chain; stage 0 samples the pad, last stage is the synced value.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_sync <= '0;
            end else if (en_i[i]) begin
                r_sync <= {r_sync[NR_SYNC_STAGES-2:0], serial_i[i]};
            end
        end

        // Debounce filter. The ">=" compare means a threshold lowered below
        // the running count accepts on the very next mismatching cycle, and
        // it also keeps the counter from ever wrapping.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_filt <= 1'b0;
                r_cnt  <= '0;
                r_prev <= 1'b0;
            end else if (en_i[i]) begin
                r_prev <= r_filt;
                if (!debounce_en_i[i]) begin
                    r_filt <= w_sync;
                    r_cnt  <= '0;
                end else if (w_sync == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt >= debounce_cycles_i) begin
                    r_filt <= w_sync;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + C_CNT_ONE;
                end
            end
        end

        assign w_filt[i] = r_filt;
        assign w_prev[i] = r_prev;
    end : g_ch

    // Edge pulses are qualified by the enable so a frozen channel that
    // happens to hold F != P cannot emit a stuck pulse.
    assign w_r_edge   =  w_filt & ~w_prev & en_i;
    assign w_f_edge   = ~w_filt &  w_prev & en_i;
    assign w_pend_set = (w_r_edge & rise_irq_en_i) | (w_f_edge & fall_irq_en_i);

    // Pending bits run every cycle regardless of enable; set beats clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_set | (r_pending & ~irq_clr_i);
        end
    end

    assign serial_o      = w_filt;
    assign r_edge_o      = w_r_edge;
    assign f_edge_o      = w_f_edge;
    assign irq_pending_o = r_pending;
    assign irq_o         = |r_pending;

endmodule : gpio_input_filter_bank
`default_nettype wire

// File: tb/tb_gpio_input_filter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_input_filter_bank
//  Description : Directed self-checking bench for gpio_input_filter_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_input_filter_bank;

    localparam int NR_CHANNELS        = 32;
    localparam int NR_SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CNT_WIDTH = 8;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic [NR_CHANNELS-1:0]        en_i;
    logic [NR_CHANNELS-1:0]        serial_i;
    logic [NR_CHANNELS-1:0]        debounce_en_i;
    logic [DEBOUNCE_CNT_WIDTH-1:0] debounce_cycles_i;
    logic [NR_CHANNELS-1:0]        rise_irq_en_i;
    logic [NR_CHANNELS-1:0]        fall_irq_en_i;
    logic [NR_CHANNELS-1:0]        irq_clr_i;
    logic [NR_CHANNELS-1:0]        serial_o;
    logic [NR_CHANNELS-1:0]        r_edge_o;
    logic [NR_CHANNELS-1:0]        f_edge_o;
    logic [NR_CHANNELS-1:0]        irq_pending_o;
    logic                          irq_o;

    int r_checks   = 0;
    int r_failures = 0;

    gpio_input_filter_bank #(
        .NR_CHANNELS        (NR_CHANNELS),
        .NR_SYNC_STAGES     (NR_SYNC_STAGES),
        .DEBOUNCE_CNT_WIDTH (DEBOUNCE_CNT_WIDTH)
    ) u_dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .en_i              (en_i),
        .serial_i          (serial_i),
        .debounce_en_i     (debounce_en_i),
        .debounce_cycles_i (debounce_cycles_i),
        .rise_irq_en_i     (rise_irq_en_i),
        .fall_irq_en_i     (fall_irq_en_i),
        .irq_clr_i         (irq_clr_i),
        .serial_o          (serial_o),
        .r_edge_o          (r_edge_o),
        .f_edge_o          (f_edge_o),
        .irq_pending_o     (irq_pending_o),
        .irq_o             (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge: drive and sample point.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    logic [NR_CHANNELS-1:0] w_seen;

    initial begin
        rst_i             = 1'b1;
        en_i              = '1;
        serial_i          = '0;
        debounce_en_i     = '0;
        debounce_cycles_i = 8'd4;
        rise_irq_en_i     = '0;
        fall_irq_en_i     = '0;
        irq_clr_i         = '0;

        // Reset state
        tick(2);
        check_eq("rst_serial", serial_o, 32'h0);
        check_eq("rst_redge", r_edge_o, 32'h0);
        check_eq("rst_fedge", f_edge_o, 32'h0);
        check_eq("rst_pending", irq_pending_o, 32'h0);
        check_eq("rst_irq", {31'd0, irq_o}, 32'h0);
        rst_i = 1'b0;
        tick(1);

        // Bypass latency on channel 0: new level 3 edges after the change
        serial_i[0] = 1'b1;
        tick(2);
        check_eq("byp_c2_serial", serial_o, 32'h0);
        tick(1);
        check_eq("byp_c3_serial", serial_o, 32'h1);
        check_eq("byp_c3_redge", r_edge_o, 32'h1);
        check_eq("byp_c3_fedge", f_edge_o, 32'h0);
        tick(1);
        check_eq("byp_c4_redge", r_edge_o, 32'h0);
        check_eq("byp_c4_serial", serial_o, 32'h1);

        // Debounce T=4 on channel 5: 3-cycle glitch rejected
        debounce_en_i[5] = 1'b1;
        w_seen = '0;
        serial_i[5] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            w_seen |= r_edge_o | f_edge_o;
        end
        serial_i[5] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            w_seen |= r_edge_o | f_edge_o;
        end
        check_eq("glitch_serial", serial_o, 32'h1);
        check_eq("glitch_edges", w_seen, 32'h0);

        // 10-cycle pulse: rise 7 edges after change, fall 7 after return
        serial_i[5] = 1'b1;
        tick(6);
        check_eq("db_rise_c6", serial_o, 32'h1);
        tick(1);
        check_eq("db_rise_c7", serial_o, 32'h21);
        check_eq("db_rise_redge", r_edge_o, 32'h20);
        tick(3);
        serial_i[5] = 1'b0;
        tick(6);
        check_eq("db_fall_c6", serial_o, 32'h21);
        tick(1);
        check_eq("db_fall_c7", serial_o, 32'h1);
        check_eq("db_fall_fedge", f_edge_o, 32'h20);
        tick(1);
        check_eq("db_fall_fedge_end", f_edge_o, 32'h0);

        // Interrupts on channel 3 (rise only)
        rise_irq_en_i[3] = 1'b1;
        serial_i[3] = 1'b1;
        tick(3);
        check_eq("irq_rise_edge", r_edge_o, 32'h8);
        check_eq("irq_pend_before", irq_pending_o, 32'h0);
        tick(1);
        check_eq("irq_pend_after", irq_pending_o, 32'h8);
        check_eq("irq_out_set", {31'd0, irq_o}, 32'h1);
        serial_i[3] = 1'b0;
        tick(5);
        check_eq("irq_fall_noset", irq_pending_o, 32'h8);
        irq_clr_i[3] = 1'b1;
        tick(1);
        irq_clr_i[3] = 1'b0;
        check_eq("irq_clr_pend", irq_pending_o, 32'h0);
        check_eq("irq_clr_out", {31'd0, irq_o}, 32'h0);
        serial_i[3] = 1'b1;
        tick(3);
        irq_clr_i[3] = 1'b1;    // coincident with the rising-edge pulse
        tick(1);
        irq_clr_i[3] = 1'b0;
        check_eq("irq_set_wins", irq_pending_o, 32'h8);
        irq_clr_i[3] = 1'b1;
        tick(1);
        irq_clr_i[3] = 1'b0;
        check_eq("irq_clr2", irq_pending_o, 32'h0);

        // Enable freeze on channel 7
        en_i[7]     = 1'b0;
        serial_i[7] = 1'b1;
        w_seen = '0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            w_seen |= (r_edge_o | f_edge_o) & 32'h80;
        end
        check_eq("frz_serial", serial_o & 32'h80, 32'h0);
        check_eq("frz_edges", w_seen, 32'h0);
        en_i[7] = 1'b1;
        tick(2);
        check_eq("frz_re_c2", serial_o & 32'h80, 32'h0);
        tick(1);
        check_eq("frz_re_c3", serial_o & 32'h80, 32'h80);
        check_eq("frz_re_redge", r_edge_o, 32'h80);

        // Reset mid-debounce: ch3 pending via fall, ch9 counter at 6 with T=10
        fall_irq_en_i[3] = 1'b1;
        serial_i[3] = 1'b0;
        tick(4);
        check_eq("pre_rst_pend", irq_pending_o, 32'h8);
        debounce_en_i[9]  = 1'b1;
        debounce_cycles_i = 8'd10;
        serial_i[9] = 1'b1;
        tick(8);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check_eq("midrst_serial", serial_o, 32'h0);
        check_eq("midrst_pend", irq_pending_o, 32'h0);
        check_eq("midrst_irq", {31'd0, irq_o}, 32'h0);
        check_eq("midrst_redge", r_edge_o, 32'h0);
        tick(12);
        check_eq("cnt_restart_c12", serial_o & 32'h200, 32'h0);
        tick(1);
        check_eq("cnt_restart_c13", serial_o & 32'h200, 32'h200);

        // Threshold lowered mid-count on channel 9
        debounce_cycles_i = 8'd200;
        serial_i[9] = 1'b0;
        tick(52);
        check_eq("thr_hold", serial_o & 32'h200, 32'h200);
        debounce_cycles_i = 8'd10;
        tick(1);
        check_eq("thr_accept", serial_o & 32'h200, 32'h0);
        check_eq("thr_fedge", f_edge_o, 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule : tb_gpio_input_filter_bank
`default_nettype wire
